// File: rtl/data_mem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes and
// controller states.
package data_mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Sign- or zero-extend a right-justified byte/half to 32 bits.
  function automatic logic [31:0] lsu_extend(input logic [15:0] v,
                                             input logic        is_half,
                                             input logic        is_unsigned);
    logic [31:0] r;
    if (is_half) r = {{16{~is_unsigned & v[15]}}, v};
    else         r = {{24{~is_unsigned & v[7]}}, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store-side byte enables and lane replication, load-side
// lane extraction with extension, plus alignment and size legality flags.
module lsu_lane_align
  import data_mem_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rword_i >> {lane_i, 3'b000};
    be_o       = 4'b0000;
    wword_o    = wdata_i;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = lsu_extend(shifted[15:0], 1'b0, unsigned_i);
      end
      SZ_HALF: begin
        misalign_o = lane_i[0];
        be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o    = {2{wdata_i[15:0]}};
        rdata_o    = lsu_extend(shifted[15:0], 1'b1, unsigned_i);
      end
      SZ_WORD: begin
        misalign_o = |lane_i;
        be_o       = 4'b1111;
        rdata_o    = rword_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory with valid/ready request/response handshake, configurable read
// latency, lane steering and fault detection; one transaction in flight.
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       ld_data;
  logic              misalign;
  logic              illegal;
  logic              fault;
  logic              accept;
  logic              we_fire;

  // BASE_ADDR is window-aligned, so the low offset bits equal the address lane.
  assign offset       = req_addr_i - BASE_ADDR;
  assign idx          = offset[IDX_W+1:2];
  assign lane         = offset[1:0];
  assign out_of_range = |offset[31:IDX_W+2];
  assign rword        = mem_q[idx];

  lsu_lane_align u_align (
    .size_i     (req_size_i),
    .unsigned_i (req_unsigned_i),
    .lane_i     (lane),
    .wdata_i    (req_wdata_i),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .rdata_o    (ld_data),
    .misalign_o (misalign),
    .illegal_o  (illegal)
  );

  assign fault   = out_of_range | misalign | illegal;
  assign accept  = req_valid_i & (state_q == ST_IDLE);
  assign we_fire = accept & req_we_i & ~fault;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          err_d   = fault;
          rdata_d = (fault | req_we_i) ? 32'h0 : ld_data;
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = (RD_LAT == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset; only enabled lanes are written.
  always_ff @(posedge clk_i) begin
    if (we_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wword[b*8 +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: three instances covering latency 1/3 and a
// relocated small window (latency 2).
module tb_data_mem_lsu;
  import data_mem_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_rdata [3];

  int n_pass  = 0;
  int n_total = 0;

  data_mem_lsu #(.DEPTH(1024), .RD_LAT(1), .BASE_ADDR(32'h0)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[0]),
    .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

  data_mem_lsu #(.DEPTH(1024), .RD_LAT(3), .BASE_ADDR(32'h0)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[1]),
    .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

  data_mem_lsu #(.DEPTH(256), .RD_LAT(2), .BASE_ADDR(32'h0000_1000)) u_win (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid[2]),
    .rsp_ready_i(rsp_ready[2]), .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]));

  // One request/response with rsp_ready held high; lat counts edges from accept
  // to the first edge that sees rsp_valid.
  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin lat = k + 1; break; end
    end
    rd = rsp_rdata[d]; er = rsp_err[d];
    if (lat < 0) begin
      n_total++;
      $display("FAIL txn_timeout dut=%0d addr=%08h no rsp_valid within 20 cycles", d, addr);
    end else begin
      @(posedge clk); #1;
    end
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b000; rsp_ready = 3'b000;
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (req_ready !== 3'b111) $display("FAIL rst_req_ready got %b exp 111", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 3'b000) $display("FAIL rst_rsp_valid got %b exp 000", rsp_valid); else n_pass++;
    n_total++; if (rsp_err !== 3'b000) $display("FAIL rst_rsp_err got %b exp 000", rsp_err); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (rsp_rdata[i] !== 32'h0) $display("FAIL rst_rdata dut=%0d got %08h exp 00000000", i, rsp_rdata[i]); else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_total++; if ({req_ready, rsp_valid} !== 6'b111000) $display("FAIL post_rst_idle got %b exp 111000", {req_ready, rsp_valid}); else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_total++; if ({er, rd} !== 33'h0) $display("FAIL sw_rsp got err=%b rdata=%08h exp err=0 rdata=0", er, rd); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL sw_latency got %0d exp 1", lat); else n_pass++;
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_10 got %08h exp DEADBEEF", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL lw_10_err got %b exp 0", er); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL lw_latency got %0d exp 1", lat); else n_pass++;
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    n_total++; if (er !== 1'b0) $display("FAIL sb_13_err got %b exp 0", er); else n_pass++;
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_13 got %08h exp FFFFFF80", rd); else n_pass++;
    txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h00000080) $display("FAIL lbu_13 got %08h exp 00000080", rd); else n_pass++;
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h80ADBEEF) $display("FAIL lw_10_after_sb got %08h exp 80ADBEEF", rd); else n_pass++;
    txn(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hFFFFFFBE) $display("FAIL lb_11 got %08h exp FFFFFFBE", rd); else n_pass++;
    txn(0, 1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h000000AD) $display("FAIL lbu_12 got %08h exp 000000AD", rd); else n_pass++;
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat);
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'hABCD1234, rd, er, lat);
    n_total++; if ({er, rd} !== 33'h0) $display("FAIL sh_22_rsp got err=%b rdata=%08h exp 0/0", er, rd); else n_pass++;
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h00001234) $display("FAIL lh_22 got %08h exp 00001234", rd); else n_pass++;
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h12340000) $display("FAIL lw_20_after_sh got %08h exp 12340000", rd); else n_pass++;
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h20, 32'h0000F00D, rd, er, lat);
    txn(0, 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hFFFFF00D) $display("FAIL lh_20 got %08h exp FFFFF00D", rd); else n_pass++;
    txn(0, 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h0000F00D) $display("FAIL lhu_20 got %08h exp 0000F00D", rd); else n_pass++;
    txn(0, 1'b1, SZ_HALF, 1'b0, 32'h21, 32'h00005678, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL sh_21_misalign got err=%b rdata=%08h exp 1/0", er, rd); else n_pass++;
    txn(0, 1'b1, SZ_WORD, 1'b0, 32'h21, 32'h99999999, rd, er, lat);
    n_total++; if (er !== 1'b1) $display("FAIL sw_21_misalign got err=%b exp 1", er); else n_pass++;
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'h1234F00D) $display("FAIL lw_20_unchanged got %08h exp 1234F00D", rd); else n_pass++;
    txn(0, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL lw_22_misalign got err=%b rdata=%08h exp 1/0", er, rd); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] rd; logic er; int lat;
    txn(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hCAFEF00D, rd, er, lat);
    n_total++; if (lat !== 3) $display("FAIL lat3_sw_latency got %0d exp 3", lat); else n_pass++;
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    // keep a conflicting store asserted while the unit is busy; it must be ignored
    req_we = 1'b1; req_wdata = 32'h0BAD0BAD;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_total++; if (rsp_valid[1] !== (k >= 2)) $display("FAIL stall_valid cycle=%0d got %b exp %b", k, rsp_valid[1], (k >= 2)); else n_pass++;
      n_total++; if (req_ready[1] !== 1'b0) $display("FAIL stall_req_ready cycle=%0d got %b exp 0", k, req_ready[1]); else n_pass++;
      if (k >= 2) begin
        n_total++; if ({rsp_err[1], rsp_rdata[1]} !== {1'b0, 32'hCAFEF00D}) $display("FAIL stall_data cycle=%0d got err=%b rdata=%08h exp 0/CAFEF00D", k, rsp_err[1], rsp_rdata[1]); else n_pass++;
      end
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    n_total++; if ({req_ready[1], rsp_valid[1]} !== 2'b10) $display("FAIL stall_release got ready/valid=%b exp 10", {req_ready[1], rsp_valid[1]}); else n_pass++;
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL busy_req_ignored got %08h exp CAFEF00D", rd); else n_pass++;
    n_total++; if (lat !== 3) $display("FAIL lat3_lw_latency got %0d exp 3", lat); else n_pass++;
  endtask

  task automatic test_window();
    logic [31:0] rd; logic er; int lat;
    txn(2, 1'b1, SZ_WORD, 1'b0, 32'h13FC, 32'h11223344, rd, er, lat);
    n_total++; if (er !== 1'b0) $display("FAIL win_sw_top_err got %b exp 0", er); else n_pass++;
    txn(2, 1'b0, SZ_WORD, 1'b0, 32'h13FC, 32'h0, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b0, 32'h11223344}) $display("FAIL win_lw_top got err=%b rdata=%08h exp 0/11223344", er, rd); else n_pass++;
    n_total++; if (lat !== 2) $display("FAIL win_latency got %0d exp 2", lat); else n_pass++;
    txn(2, 1'b0, SZ_WORD, 1'b0, 32'h1400, 32'h0, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL win_lw_above got err=%b rdata=%08h exp 1/0", er, rd); else n_pass++;
    txn(2, 1'b0, SZ_WORD, 1'b0, 32'h0FFC, 32'h0, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL win_lw_below got err=%b rdata=%08h exp 1/0", er, rd); else n_pass++;
    txn(2, 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hA5A5A5A5, rd, er, lat);
    txn(2, 1'b1, SZ_ILL, 1'b0, 32'h1000, 32'hFFFFFFFF, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL win_size11 got err=%b rdata=%08h exp 1/0", er, rd); else n_pass++;
    txn(2, 1'b1, SZ_WORD, 1'b0, 32'h1400, 32'h00000BAD, rd, er, lat);
    n_total++; if (er !== 1'b1) $display("FAIL win_sw_above_err got %b exp 1", er); else n_pass++;
    txn(2, 1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, rd, er, lat);
    n_total++; if (rd !== 32'hA5A5A5A5) $display("FAIL win_no_write got %08h exp A5A5A5A5", rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic seen;
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h80; req_wdata = 32'h55;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    n_total++; if (req_ready[1] !== 1'b0) $display("FAIL mid_in_wait got req_ready=%b exp 0", req_ready[1]); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({rsp_valid[1], req_ready[1]} !== 2'b01) $display("FAIL mid_async_rst got valid/ready=%b exp 01", {rsp_valid[1], req_ready[1]}); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) seen = 1'b1;
    end
    rsp_ready[1] = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL mid_dropped_rsp got rsp_valid seen=%b exp 0", seen); else n_pass++;
    txn(1, 1'b0, SZ_WORD, 1'b0, 32'h80, 32'h0, rd, er, lat);
    n_total++; if ({er, rd} !== {1'b0, 32'h55}) $display("FAIL mid_store_kept got err=%b rdata=%08h exp 0/00000055", er, rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall();
    test_window();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Parametrised successor to the single-cycle data memory. It adds a valid/ready request/response handshake, a configurable read latency, and in-block byte/half/word lane steering with sign/zero extension. It also detects misaligned, out-of-window and illegal-size accesses. It sits between the MEM stage / load-store unit and the data array, so the core no longer generates strobes or does load extension itself.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
RD_LAT, 1, cycles from request acceptance to rsp_valid (legal 1..4)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4 aligned

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores and words
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access faulted; no memory side effect

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Array contents are not reset.
- FSM IDLE -> WAIT -> RESP -> IDLE; one outstanding transaction.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at a rising edge. On handshake, go to WAIT with count=RD_LAT-1. If RD_LAT=1, go directly to RESP.
- WAIT: req_ready=0. Decrement count each cycle; at count 0 go to RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready, then go to IDLE.
- Latency: rsp_valid rises exactly RD_LAT cycles after the accept edge when no stall occurs. Minimum request spacing is RD_LAT+1 cycles.
- Offset = req_addr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2].
- Error conditions, evaluated at accept:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - offset >= DEPTH*4 (unsigned)
  On error: no write, rsp_err=1, rsp_rdata=0.
- Store: committed to the array at the accept edge. Byte lane k=addr[1:0] gets wdata[7:0]. Half gets wdata[15:0] into lanes {addr[1],0} and {addr[1],1}. Word writes all 4 lanes. Unselected lanes are unchanged. Response is rsp_rdata=0, rsp_err=0.
- Load: the array word is captured at the accept edge into a data register. The selected lane(s) are shifted to bit 0, then sign-extended (req_unsigned=0) or zero-extended (1). The result is registered and held through RESP.
- Read-after-write: a load accepted after a store's response returns the new data.
- Reset mid-transaction: the in-flight response is dropped and the FSM returns to IDLE. A store committed at its accept edge remains in memory.
- req_valid while not ready: ignored; the requester holds the request.

Decomposition:
- Shared package: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10; FSM state encoding.
- Sub-module lsu_lane_align (combinational):
  - store side: size + addr[1:0] + wdata -> 4-bit byte enable + lane-replicated write word
  - load side: size + unsigned + addr[1:0] + word -> extended data
  - misalignment flag
- The top holds the FSM, latency counter, array, response registers and range check.

Test Plan:
- RD_LAT=1, BASE=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 1 cycle after accept, rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x13, then LB @0x13 -> rdata=0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
- SH 0x1234 @0x22, then LH @0x22 -> 0x00001234. SH @0x21 -> err=1, rdata=0, and LW @0x20 is unchanged.
- RD_LAT=3: accept at cycle 0, hold rsp_ready=0 for 5 cycles -> rsp_valid from cycle 3, data stable throughout, req_ready=0 until the cycle after rsp_ready.
- BASE=0x1000, DEPTH=256: load @0x13FC -> ok; @0x1400 and @0x0FFC -> err=1. size=11 -> err=1, with no write.
- Reset asserted asynchronously during WAIT after SW 0x55 -> rsp_valid/req_ready immediately return to 0/1, no response is emitted, and a later LW returns 0x55.
